// File: rtl/riscv_pkg.sv
// Shared RV32 core constants: ALU controls, M-extension funct3 codes and
// multiply/divide FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'b00,
    MD_CALC  = 2'b01,
    MD_FIXUP = 2'b10,
    MD_DONE  = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_datapath_step.sv
// One iteration of the muldiv datapath: radix-2 shift-add for multiply
// ({hi, multiplier}) or restoring shift-subtract for divide ({rem, quotient}).
module muldiv_datapath_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN-1:0] hi_s;
  logic [XLEN-1:0] lo_s;
  logic [XLEN:0]   add_s;
  logic [XLEN:0]   shifted_s;
  logic [XLEN:0]   diff_s;

  assign hi_s = acc[2*XLEN-1:XLEN];
  assign lo_s = acc[XLEN-1:0];

  // Remainder stays below the divisor, so bit XLEN of diff_s is a pure borrow.
  always_comb begin
    add_s     = {1'b0, hi_s} + {1'b0, opnd};
    shifted_s = {hi_s, lo_s[XLEN-1]};
    diff_s    = shifted_s - {1'b0, opnd};
    acc_next  = {(2*XLEN){1'b0}};
    if (is_div) begin
      if (!diff_s[XLEN]) begin
        acc_next = {diff_s[XLEN-1:0], lo_s[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {shifted_s[XLEN-1:0], lo_s[XLEN-2:0], 1'b0};
      end
    end else begin
      if (lo_s[0]) begin
        acc_next = {add_s, lo_s[XLEN-1:1]};
      end else begin
        acc_next = {1'b0, hi_s, lo_s[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplies.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  md_state_e         state_r, state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [2*XLEN-1:0] acc_r, acc_step_s;
  logic [XLEN-1:0]   opnd_r;
  logic [2:0]        op_r;
  logic              neg_r, busy_r, done_r;
  logic [XLEN-1:0]   result_r;

  logic              accept_s, sign_a_s, sign_b_s, neg_s, special_s, fast_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s, special_val_s, fast_val_s, fixup_val_s;
  logic [2*XLEN-1:0] prod_s;

  muldiv_datapath_step #(.XLEN(XLEN)) u_step (
    .is_div   (op_r[2]),
    .acc      (acc_r),
    .opnd     (opnd_r),
    .acc_next (acc_step_s)
  );

  // Operand magnitudes, result sign and special divides, decided at acceptance.
  always_comb begin
    sign_a_s = 1'b0;
    sign_b_s = 1'b0;
    neg_s    = 1'b0;
    case (op)
      MD_MULH, MD_DIV: begin
        sign_a_s = A[XLEN-1];
        sign_b_s = B[XLEN-1];
        neg_s    = A[XLEN-1] ^ B[XLEN-1];
      end
      MD_REM: begin
        sign_a_s = A[XLEN-1];
        sign_b_s = B[XLEN-1];
        neg_s    = A[XLEN-1];
      end
      MD_MULHSU: begin
        sign_a_s = A[XLEN-1];
        neg_s    = A[XLEN-1];
      end
      default: begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        neg_s    = 1'b0;
      end
    endcase
    mag_a_s = sign_a_s ? -A : A;
    mag_b_s = sign_b_s ? -B : B;
    special_s     = 1'b0;
    special_val_s = {XLEN{1'b0}};
    if (op[2] && (B == {XLEN{1'b0}})) begin
      special_s     = 1'b1;
      special_val_s = op[1] ? A : {XLEN{1'b1}};
    end else if (op[2] && !op[0] && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == {XLEN{1'b1}})) begin
      special_s     = 1'b1;
      special_val_s = op[1] ? {XLEN{1'b0}} : A;
    end else begin
      special_s     = 1'b0;
      special_val_s = {XLEN{1'b0}};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa_s, fb_s;
  logic signed [2*XLEN+1:0] fp_s;

  // Single-cycle 33x33 signed product covering all four multiply flavours.
  always_comb begin
    fa_s       = $signed({((op == MD_MULH) || (op == MD_MULHSU)) & A[XLEN-1], A});
    fb_s       = $signed({(op == MD_MULH) & B[XLEN-1], B});
    fp_s       = fa_s * fb_s;
    fast_s     = ~op[2];
    fast_val_s = (op == MD_MUL) ? fp_s[XLEN-1:0] : fp_s[2*XLEN-1:XLEN];
  end
`else
  assign fast_s     = 1'b0;
  assign fast_val_s = {XLEN{1'b0}};
`endif

  // Two's-complement correction and word selection once iterations finish.
  always_comb begin
    prod_s = neg_r ? -acc_r : acc_r;
    case (op_r)
      MD_MUL:                        fixup_val_s = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fixup_val_s = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               fixup_val_s = neg_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
      MD_REM, MD_REMU:               fixup_val_s = neg_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
      default:                       fixup_val_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state logic; kill beats start in IDLE and aborts CALC/FIXUP.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      MD_IDLE: begin
        if (start && !kill) begin
          accept_s = 1'b1;
          state_s  = (special_s || fast_s) ? MD_DONE : MD_CALC;
        end else begin
          state_s  = MD_IDLE;
        end
      end
      MD_CALC: begin
        if (kill) begin
          state_s = MD_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_s = MD_FIXUP;
        end else begin
          state_s = MD_CALC;
        end
      end
      MD_FIXUP: state_s = kill ? MD_IDLE : MD_DONE;
      MD_DONE:  state_s = MD_IDLE;
      default:  state_s = MD_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= MD_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {(2*XLEN){1'b0}};
      opnd_r   <= {XLEN{1'b0}};
      op_r     <= 3'b000;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == MD_CALC) || (state_s == MD_FIXUP);
      done_r  <= (state_r == MD_DONE);
      if (accept_s) begin
        op_r   <= op;
        neg_r  <= neg_s;
        cnt_r  <= {CNT_W{1'b0}};
        opnd_r <= op[2] ? mag_b_s : mag_a_s;
        acc_r  <= {{XLEN{1'b0}}, (op[2] ? mag_a_s : mag_b_s)};
        if (special_s) begin
          result_r <= special_val_s;
        end else if (fast_s) begin
          result_r <= fast_val_s;
        end else begin
          result_r <= result_r;
        end
      end else if (state_r == MD_CALC) begin
        acc_r <= acc_step_s;
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if ((state_r == MD_FIXUP) && !kill) begin
        result_r <= fixup_val_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against a timeline/arithmetic model,
// with directed literal cases for arithmetic, latency, kill and async reset.
module tb_muldiv_unit;

  logic        clk, rst_n, start, kill;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
    .A(A), .B(B), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 34;
`endif

  int n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0, done_cyc = -1;
  logic        m_active = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  int          m_age = 0, m_lat = 0;
  logic [31:0] m_pend = 32'd0, m_result = 32'd0;
  logic        probe = 1'b0, lit_req = 1'b0;
  logic [31:0] lit_exp = 32'd0;
  int          lit_base = 0, lit_ndone = 0, lit_acc = 0, lit_lat = -1;

  typedef struct { logic [2:0] o; logic [31:0] a; logic [31:0] b; logic [31:0] e; int lat; } vec_t;
  vec_t tbl [11];

  // RV32M arithmetic from first principles on 64-bit values.
  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'sd0;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    if (!o[2]) return LAT_MUL;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Advance the model by one rising edge given the inputs sampled there.
  task automatic model_edge(input logic st, input logic kl, input logic [2:0] o,
                            input logic [31:0] a, input logic [31:0] b);
    m_done = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0; m_busy = 1'b0; m_result = 32'd0;
    end else if (m_active) begin
      if (kl && m_lat == 34 && m_age <= 32) begin
        m_active = 1'b0; m_busy = 1'b0;
      end else begin
        m_age++;
        m_busy = (m_lat == 34) && (m_age <= 32);
        if (m_age == m_lat) begin
          m_done = 1'b1; m_result = m_pend; m_active = 1'b0;
        end
      end
    end else if (st && !kl) begin
      m_active = 1'b1; m_age = 0;
      m_lat = lat_of(o, a, b); m_pend = ref_md(o, a, b);
      m_busy = (m_lat == 34);
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic tick(input logic st, input logic kl, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] b);
    start = st; kill = kl; op = o; A = a; B = b;
    @(posedge clk);
    cyc++;
    model_edge(st, kl, o, a, b);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic lit_check(input logic [31:0] e, input int ndone, input int lat);
    lit_exp = e; lit_ndone = ndone; lit_lat = lat; lit_req = 1'b1;
    idle(1);
    lit_req = 1'b0;
  endtask

  task automatic run_lit(input vec_t v);
    lit_base = done_cnt;
    tick(1'b1, 1'b0, v.o, v.a, v.b);
    lit_acc = cyc;
    idle(36);
    lit_check(v.e, 1, v.lat);
  endtask

  // Per-cycle comparison against the model, plus directed literal checks.
  always @(negedge clk or posedge probe) begin
    n_vec++;
    if (busy !== m_busy) begin
      n_err++; $display("FAIL busy cyc=%0d dut=%b model=%b", cyc, busy, m_busy);
    end
    n_vec++;
    if (done !== m_done) begin
      n_err++; $display("FAIL done cyc=%0d dut=%b model=%b", cyc, done, m_done);
    end
    if (m_done || !m_active) begin
      n_vec++;
      if (result !== m_result) begin
        n_err++; $display("FAIL result cyc=%0d dut=%h model=%h", cyc, result, m_result);
      end
    end
    if (done === 1'b1) begin
      done_cnt++; done_cyc = cyc;
    end
    if (lit_req) begin
      n_vec++;
      if (result !== lit_exp) begin
        n_err++; $display("FAIL lit_result cyc=%0d dut=%h want=%h", cyc, result, lit_exp);
      end
      n_vec++;
      if (done_cnt - lit_base != lit_ndone) begin
        n_err++; $display("FAIL done_pulses cyc=%0d got=%0d want=%0d", cyc, done_cnt - lit_base, lit_ndone);
      end
      if (lit_lat >= 0) begin
        n_vec++;
        if (done_cyc - lit_acc != lit_lat) begin
          n_err++; $display("FAIL latency cyc=%0d got=%0d want=%0d", cyc, done_cyc - lit_acc, lit_lat);
        end
      end
    end
  end

  initial begin
    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_MUL};
    tbl[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL};
    tbl[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, LAT_MUL};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, LAT_MUL};
    tbl[4]  = '{3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 34};
    tbl[5]  = '{3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 34};
    tbl[6]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    tbl[7]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    tbl[8]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[9]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    tbl[10] = '{3'd5, 32'd20,         32'd3,         32'd6,         34};

    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    idle(2);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_lit(tbl[i]);

    // kill mid-divide; a start while busy must be ignored
    lit_base = done_cnt;
    tick(1'b1, 1'b0, 3'd4, 32'd100, 32'd7);
    idle(4);
    tick(1'b1, 1'b0, 3'd0, 32'd3, 32'd5);
    idle(4);
    tick(1'b0, 1'b1, 3'd0, 32'd0, 32'd0);
    idle(40);
    lit_check(32'd6, 0, -1);

    // asynchronous reset in the middle of CALC
    tick(1'b1, 1'b0, 3'd4, 32'd1000, 32'd7);
    idle(10);
    #1;
    rst_n = 1'b0;
    m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_result = 32'd0;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    idle(2);
    rst_n = 1'b1;
    run_lit('{3'd4, 32'd1000, 32'd7, 32'd142, 34});

    for (int i = 0; i < 8000; i++)
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
           3'($urandom_range(0, 7)), pick(), pick());
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
